// File: rtl/conv_layer_sequencer_if.sv
// Avalon-MM style register/memory bus bundle shared by the CPU slave port,
// the SDRAM descriptor master and the conv controller master.
interface conv_layer_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Conv layer sequencer: walks a table of 6-word layer descriptors in SDRAM,
// programs and starts the conv controller once per layer, and waits for it to
// finish. The CPU sees a 4-register control/status port.
module conv_layer_sequencer #(
    parameter int CNT_W      = 16,
    parameter int DESC_WORDS = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    conv_layer_sequencer_if.slave  cpu,
    conv_layer_sequencer_if.master sdram,
    conv_layer_sequencer_if.master conv
);
    localparam logic [31:0]      DESC_STRIDE = 32'(4 * DESC_WORDS);
    localparam logic [2:0]       LAST_WORD   = 3'(DESC_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CHECK, S_PROG, S_START, S_GAP, S_WAIT, S_FINISH
    } state_t;

    state_t           state, state_next;
    logic [31:0]      desc_base;
    logic [31:0]      desc_ptr;     // byte address of the descriptor being worked on
    logic [CNT_W-1:0] desc_count;
    logic [CNT_W-1:0] progress;     // doubles as the descriptor index
    logic             done, err, busy;
    logic [2:0]       idx;          // word index in FETCH/PROG, gap counter in S_GAP
    logic [31:0]      desc_buf [DESC_WORDS];

    logic start_req, desc_bad, last_desc;
    logic unused_ok;

    assign busy      = (state != S_IDLE);
    assign start_req = (state == S_IDLE) && cpu.write && (cpu.address == 2'd0) && cpu.writedata[0];
    assign desc_bad  = (desc_buf[5] < 32'd3) || (desc_buf[3] == '0) || (desc_buf[4] == '0);
    assign last_desc = ((progress + CNT_ONE) == desc_count);
    assign unused_ok = ^{cpu.read, conv.readdata};

    assign cpu.waitrequest = 1'b0;

    // CPU register readback, combinational in the same cycle as the address
    always_comb begin
        cpu.readdata = '0;
        case (cpu.address)
            2'd0:    cpu.readdata = {29'b0, err, done, busy};
            2'd1:    cpu.readdata = desc_base;
            2'd2:    cpu.readdata[CNT_W-1:0] = desc_count;
            default: cpu.readdata[CNT_W-1:0] = progress;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state and bus strobes; strobes are a pure function of state, so they hold during stalls
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
        state_next       = state;
        sdram.address    = '0;
        sdram.read       = 1'b0;
        sdram.write      = 1'b0;
        sdram.writedata  = '0;
        conv.address     = '0;
        conv.read        = 1'b0;
        conv.write       = 1'b0;
        conv.writedata   = '0;
        unique case (state)
            S_IDLE:   if (start_req) state_next = (desc_count == '0) ? S_FINISH : S_FETCH;
            S_FETCH: begin
                sdram.read    = 1'b1;
                sdram.address = desc_ptr + {27'b0, idx, 2'b00};
                if (!sdram.waitrequest && idx == LAST_WORD) state_next = S_CHECK;
            end
            S_CHECK:  state_next = desc_bad ? S_IDLE : S_PROG;
            S_PROG: begin
                conv.write     = 1'b1;
                conv.address   = idx + 3'd1;
                conv.writedata = desc_buf[idx];
                if (!conv.waitrequest && idx == LAST_WORD) state_next = S_START;
            end
            S_START: begin
                conv.write     = 1'b1;
                conv.writedata = 32'd1;
                if (!conv.waitrequest) state_next = S_GAP;
            end
            // The controller may still look idle right after the start write, so let it settle
            S_GAP:    if (idx == 3'd1) state_next = S_WAIT;
            S_WAIT: begin
                conv.read = 1'b1;
                if (!conv.waitrequest) state_next = last_desc ? S_IDLE : S_FETCH;
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Register file, descriptor buffer and sequencing counters
    always_ff @(posedge clk) begin
        if (reset) begin
            desc_base  <= '0;
            desc_count <= '0;
            desc_ptr   <= '0;
            progress   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            idx        <= '0;
            // NOTE: the descriptor buffer is a handful of flops with a defined reset value, so it is cleared here.
            for (int k = 0; k < DESC_WORDS; k++) desc_buf[k] <= '0;
        end else begin
            if (cpu.write && !busy) begin
                case (cpu.address)
                    2'd1:    desc_base  <= {cpu.writedata[31:2], 2'b00};
                    2'd2:    desc_count <= cpu.writedata[CNT_W-1:0];
                    default: ;
                endcase
            end
            unique case (state)
                S_IDLE: if (start_req) begin
                    done     <= 1'b0;
                    err      <= 1'b0;
                    progress <= '0;
                    desc_ptr <= desc_base;
                    idx      <= '0;
                end
                S_FETCH: if (!sdram.waitrequest) begin
                    desc_buf[idx] <= sdram.readdata;
                    idx           <= (idx == LAST_WORD) ? 3'd0 : idx + 3'd1;
                end
                S_CHECK: if (desc_bad) begin
                    err  <= 1'b1;
                    done <= 1'b1;
                end
                S_PROG:  if (!conv.waitrequest) idx <= (idx == LAST_WORD) ? 3'd0 : idx + 3'd1;
                S_START: if (!conv.waitrequest) idx <= '0;
                S_GAP:   idx <= idx + 3'd1;
                S_WAIT: if (!conv.waitrequest) begin
                    progress <= progress + CNT_ONE;
                    desc_ptr <= desc_ptr + DESC_STRIDE;
                    idx      <= '0;
                    if (last_desc) done <= 1'b1;
                end
                S_FINISH: done <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench for conv_layer_sequencer: a transaction-level model builds
// the expected bus transfer list from the descriptor table, and a compare
// process checks every accepted transfer, stall stability and idle strobes.
module tb_conv_layer_sequencer;
    typedef logic [95:0] val_t;
    typedef struct packed {
        logic [1:0]  bus;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    localparam logic [1:0] BUS_RD   = 2'd0;  // SDRAM descriptor read
    localparam logic [1:0] BUS_WR   = 2'd1;  // conv register write
    localparam logic [1:0] BUS_POLL = 2'd2;  // conv completion read

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conv_layer_sequencer_if #(.ADDR_W(2))  cpu_if ();
    conv_layer_sequencer_if #(.ADDR_W(32)) sdram_if ();
    conv_layer_sequencer_if #(.ADDR_W(3))  conv_if ();

    conv_layer_sequencer #(.CNT_W(16), .DESC_WORDS(6)) dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (cpu_if),
        .sdram (sdram_if),
        .conv  (conv_if)
    );

    logic [31:0] mem [1024];
    assign sdram_if.readdata = mem[sdram_if.address[11:2]];
    assign conv_if.readdata  = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;
    xfer_t exp_q [$];
    logic [2:0] m_ctrl;
    int m_prog;
    bit stall_mode = 1'b0;
    int hold_target = 0;
    int hold_cnt = 0;
    int gap_stage = 0;
    int conv_wr_cnt = 0;
    logic stalled_prev = 1'b0;
    logic [69:0] prev_snap = '0;

    task automatic check(input string name, input val_t actual, input val_t expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: expected transfer list and final status for one run
    task automatic model_run(input logic [31:0] base, input int count);
        logic [31:0] w [6];
        logic [31:0] a;
        bit bad;
        exp_q.delete();
        bad = 1'b0;
        m_prog = 0;
        for (int i = 0; i < count; i++) begin
            for (int k = 0; k < 6; k++) begin
                a = base + 32'(24 * i + 4 * k);
                w[k] = mem[a[11:2]];
                exp_q.push_back('{BUS_RD, a, 32'h0});
            end
            if (w[5] < 3 || w[3] == 0 || w[4] == 0) begin
                bad = 1'b1;
                break;
            end
            for (int j = 1; j <= 6; j++) exp_q.push_back('{BUS_WR, 32'(j), w[j-1]});
            exp_q.push_back('{BUS_WR, 32'h0, 32'h1});
            exp_q.push_back('{BUS_POLL, 32'h0, 32'h0});
            m_prog++;
        end
        m_ctrl = bad ? 3'b110 : 3'b010;
    endtask

    task automatic put_desc(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3, input logic [31:0] w4,
                            input logic [31:0] w5);
        logic [31:0] w [6];
        logic [31:0] p;
        w = '{w0, w1, w2, w3, w4, w5};
        for (int k = 0; k < 6; k++) begin
            p = a + 32'(4 * k);
            mem[p[11:2]] = w[k];
        end
    endtask

    // All CPU-side tasks are entered one time unit after a rising edge
    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        cpu_if.address   = a;
        cpu_if.writedata = d;
        cpu_if.write     = 1'b1;
        @(posedge clk); #1;
        cpu_if.write     = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        cpu_if.address = a;
        cpu_if.read    = 1'b1;
        #1;
        d = cpu_if.readdata;
        cpu_if.read    = 1'b0;
    endtask

    task automatic start_run(input logic [31:0] base, input int count, input bit stall, input int hold);
        stall_mode  = stall;
        hold_target = hold;
        write_reg(2'd1, base);
        write_reg(2'd2, 32'(count));
        model_run(base, count);
        write_reg(2'd0, 32'h1);
    endtask

    task automatic finish_run();
        logic [31:0] d;
        d = 32'h1;
        for (int c = 0; c < 20000 && d[0]; c++) begin
            read_reg(2'd0, d);
            if (d[0]) begin
                @(posedge clk); #1;
            end
        end
        check("idle_timeout", val_t'(d[0]), '0);
        check("queue_drained", val_t'(exp_q.size()), '0);
        read_reg(2'd0, d);
        check("ctrl_end", val_t'(d), val_t'(m_ctrl));
        read_reg(2'd3, d);
        check("progress_end", val_t'(d), val_t'(m_prog));
    endtask

    // Slave-side stall generator, updated just after each rising edge
    always @(posedge clk) begin
        #1;
        sdram_if.waitrequest = stall_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        if (conv_if.read && hold_cnt < hold_target) begin
            conv_if.waitrequest = 1'b1;
            hold_cnt++;
        end else begin
            conv_if.waitrequest = stall_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (!conv_if.read) hold_cnt = 0;
    end

    // Compare process: values sampled mid-cycle describe the transfer at the next rising edge
    always @(negedge clk) begin : cmp
        logic [2:0]  strobes;
        logic [69:0] snap;
        xfer_t       got;
        logic        hit;
        strobes = {sdram_if.read, conv_if.write, conv_if.read};
        snap    = {sdram_if.read, sdram_if.address, conv_if.write, conv_if.read,
                   conv_if.address, conv_if.writedata};
        if (reset) begin
            exp_q.delete();
            gap_stage    = 0;
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) check("stall_hold", val_t'(snap), val_t'(prev_snap));
            check("one_strobe", val_t'($countones(strobes) > 1), '0);
            if (exp_q.size() == 0 && gap_stage == 0) check("idle_strobes", val_t'(strobes), '0);
            if (gap_stage == 1 || gap_stage == 2) begin
                check("poll_gap", val_t'(strobes), '0);
                gap_stage++;
            end else if (gap_stage == 3) begin
                check("poll_begin", val_t'(strobes), val_t'(3'b001));
                gap_stage = 0;
            end
            hit = 1'b1;
            got = '0;
            if (sdram_if.read && !sdram_if.waitrequest)
                got = '{BUS_RD, sdram_if.address, 32'h0};
            else if (conv_if.write && !conv_if.waitrequest)
                got = '{BUS_WR, {29'b0, conv_if.address}, conv_if.writedata};
            else if (conv_if.read && !conv_if.waitrequest)
                got = '{BUS_POLL, {29'b0, conv_if.address}, 32'h0};
            else
                hit = 1'b0;
            if (hit) begin
                if (exp_q.size() == 0) begin
                    check("xfer_unexpected", val_t'({1'b1, got}), '0);
                end else begin
                    check("xfer", val_t'(got), val_t'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                if (got.bus == BUS_WR) conv_wr_cnt++;
                if (got.bus == BUS_WR && got.addr == 32'h0) gap_stage = 1;
            end
            stalled_prev = (sdram_if.read && sdram_if.waitrequest) ||
                           ((conv_if.write || conv_if.read) && conv_if.waitrequest);
            prev_snap = snap;
        end
    end

    initial begin
        logic [31:0] d;
        logic [31:0] base;
        int cnt, c0;
        cpu_if.address   = '0;
        cpu_if.read      = 1'b0;
        cpu_if.write     = 1'b0;
        cpu_if.writedata = '0;
        for (int k = 0; k < 1024; k++) mem[k] = 32'(k) ^ 32'h5A5A_0000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobes", val_t'({sdram_if.read, conv_if.write, conv_if.read}), '0);
        check("rst_cpu_wait", val_t'(cpu_if.waitrequest), '0);
        for (int r = 0; r < 4; r++) begin
            read_reg(2'(r), d);
            check("rst_reg", val_t'(d), '0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // Single layer with a 50-cycle completion stall
        put_desc(32'h100, 32'h1000, 32'h2000, 32'h3000, 32'd2, 32'd4, 32'd28);
        start_run(32'h100, 1, 1'b0, 50);
        check("pin1_len", val_t'(exp_q.size()), val_t'(14));
        check("pin1_last_rd", val_t'(exp_q[5]), val_t'({BUS_RD, 32'h114, 32'h0}));
        check("pin1_j1", val_t'(exp_q[6]), val_t'({BUS_WR, 32'd1, 32'h1000}));
        check("pin1_j6", val_t'(exp_q[11]), val_t'({BUS_WR, 32'd6, 32'd28}));
        check("pin1_go", val_t'(exp_q[12]), val_t'({BUS_WR, 32'd0, 32'd1}));
        finish_run();
        read_reg(2'd0, d);
        check("t1_ctrl", val_t'(d), val_t'(3'b010));
        read_reg(2'd3, d);
        check("t1_progress", val_t'(d), val_t'(1));

        // Three layers; busy-time writes of base, count and start must be ignored
        put_desc(32'h200, 32'hA0, 32'hA1, 32'hA2, 32'd1, 32'd8, 32'd3);
        put_desc(32'h218, 32'hB0, 32'hB1, 32'hB2, 32'd3, 32'd2, 32'd64);
        put_desc(32'h230, 32'hC0, 32'hC1, 32'hC2, 32'd7, 32'd1, 32'd5);
        start_run(32'h200, 3, 1'b0, 0);
        check("pin3_len", val_t'(exp_q.size()), val_t'(42));
        check("pin3_desc1", val_t'(exp_q[14].addr), val_t'(32'h218));
        check("pin3_desc2", val_t'(exp_q[28].addr), val_t'(32'h230));
        repeat (15) @(posedge clk);
        #1;
        write_reg(2'd1, 32'hDEAD0);
        write_reg(2'd2, 32'd9);
        write_reg(2'd0, 32'h1);
        read_reg(2'd0, d);
        check("busy_midrun", val_t'(d), val_t'(3'b001));
        finish_run();
        read_reg(2'd1, d);
        check("base_kept", val_t'(d), val_t'(32'h200));
        read_reg(2'd2, d);
        check("count_kept", val_t'(d), val_t'(3));

        // Same three layers under random stalls on both buses
        start_run(32'h200, 3, 1'b1, 3);
        finish_run();

        // Bad second descriptor (row length 2)
        put_desc(32'h300, 32'hD0, 32'hD1, 32'hD2, 32'd1, 32'd1, 32'd3);
        put_desc(32'h318, 32'hE0, 32'hE1, 32'hE2, 32'd1, 32'd1, 32'd2);
        start_run(32'h300, 3, 1'b1, 0);
        check("pin_bad_len", val_t'(exp_q.size()), val_t'(20));
        finish_run();
        read_reg(2'd0, d);
        check("bad_ctrl", val_t'(d), val_t'(3'b110));
        read_reg(2'd3, d);
        check("bad_progress", val_t'(d), val_t'(1));

        // Zero-count start: busy for one cycle, then done with no traffic
        start_run(32'h100, 0, 1'b0, 0);
        read_reg(2'd0, d);
        check("cnt0_busy", val_t'(d), val_t'(3'b001));
        @(posedge clk); #1;
        read_reg(2'd0, d);
        check("cnt0_done", val_t'(d), val_t'(3'b010));
        finish_run();

        // Reset during programming, after the third register write
        c0 = conv_wr_cnt;
        start_run(32'h200, 3, 1'b0, 0);
        for (int c = 0; c < 500 && (conv_wr_cnt - c0) < 3; c++) begin
            @(posedge clk); #1;
        end
        check("prog_reached", val_t'(conv_wr_cnt - c0), val_t'(3));
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_strobes", val_t'({sdram_if.read, conv_if.write, conv_if.read}), '0);
        read_reg(2'd0, d);
        check("abort_ctrl", val_t'(d), '0);
        read_reg(2'd1, d);
        check("abort_base", val_t'(d), '0);
        reset = 1'b0;
        @(posedge clk); #1;
        start_run(32'h200, 3, 1'b0, 0);
        finish_run();

        // Randomised descriptor tables, counts, bases and stalls
        for (int r = 0; r < 8; r++) begin
            base = 32'($urandom_range(0, 320)) << 2;
            cnt  = $urandom_range(1, 4);
            for (int i = 0; i < cnt; i++) begin
                put_desc(base + 32'(24 * i), $urandom, $urandom, $urandom,
                         ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 64)),
                         ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 64)),
                         ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 2))
                                                     : 32'($urandom_range(3, 512)));
            end
            start_run(base, cnt, 1'($urandom_range(0, 1)), $urandom_range(0, 8));
            finish_run();
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
Hardware scheduler that runs a list of convolution layers back to back without CPU involvement per layer. It fetches 6-word layer descriptors from SDRAM over an Avalon master. It programs the conv controller's CPU-facing register port (regs 1..6), then starts it by writing reg 0. It waits for completion by issuing a read of reg 0, which stalls on waitrequest until the controller returns to idle. The CPU sees a 4-register slave: control/status, descriptor base, descriptor count, progress.

Parameters:
CNT_W, 16, width of descriptor count and progress counters
DESC_WORDS, 6, words per descriptor (fixed; byte stride = 4*DESC_WORDS = 24)

Ports:
clk  input  1  clock (single clock domain)
reset  input  1  synchronous, active-high reset
slave_address  input  2  CPU register select
slave_read  input  1  CPU read strobe
slave_readdata  output  32  CPU read data (combinational, same cycle)
slave_write  input  1  CPU write strobe
slave_writedata  input  32  CPU write data
slave_waitrequest  output  1  tied 0
master_waitrequest  input  1  SDRAM stall
master_address  output  32  SDRAM byte address
master_read  output  1  SDRAM read strobe
master_readdata  input  32  SDRAM data, valid in cycle read accepted (waitrequest low)
conv_waitrequest  input  1  conv controller slave stall
conv_address  output  3  conv controller register select
conv_read  output  1  conv controller read strobe
conv_readdata  input  32  ignored except for handshake
conv_write  output  1  conv controller write strobe
conv_writedata  output  32  conv controller write data

Behaviour:
- Reset value of all outputs: 0, except slave_readdata, which reflects the reset register values. Reset state: IDLE. CTRL.busy=0, done=0, err=0. DESC_BASE=0, DESC_COUNT=0, PROGRESS=0, descriptor buffer cleared.
- Reset asserted mid-operation aborts immediately. Outputs drop to 0 next cycle and no further SDRAM or conv transactions occur.
- CPU registers:
  - 0 CTRL: write with bit0=1 starts the sequence. Read returns {29'b0, err, done, busy}.
  - 1 DESC_BASE: byte address, bits[1:0] forced to 0.
  - 2 DESC_COUNT: CNT_W bits.
  - 3 PROGRESS: read-only, number of completed descriptors.
- While busy, writes to regs 1-2 are ignored, and a start write is ignored.
- Start from IDLE: clears done, err and PROGRESS, sets busy, sets index i=0.
  - If DESC_COUNT==0: busy clears and done sets the next cycle. No bus traffic.
- Avalon rule, both masters: address, read/write and writedata are held stable while the respective waitrequest=1. A transfer completes in the first cycle with waitrequest=0. Strobes deassert the cycle after completion unless the next transfer is issued back to back.
- States:
  - FETCH: read word k=0..5 at DESC_BASE + 24*i + 4*k into buf[k]. After k=5 completes, go to CHECK.
  - CHECK (1 cycle): if buf[5] (row length) < 3, or buf[3] (layers) == 0, or buf[4] (filters) == 0: set err, set done, clear busy, go to IDLE. PROGRESS keeps its count of completed layers. Otherwise go to PROG.
  - PROG: write conv_address=j, data=buf[j-1], for j=1..6 in order. After j=6 completes, go to START.
  - START: write conv_address=0, data=1. On completion go to WAITDONE.
  - WAITDONE: assert conv_read with conv_address=0 and hold it until conv_waitrequest=0. On completion PROGRESS+=1 and i+=1. If i == DESC_COUNT: clear busy, set done, go to IDLE. Else go to FETCH.
- The first WAITDONE read may be accepted before the controller leaves its idle state. WAITDONE therefore first idles 2 cycles after the START write completes, then asserts conv_read.
- Address arithmetic is 32-bit and wraps modulo 2^32 with no error.
- CPU read of CTRL in the same cycle that done sets returns the pre-update value; the new value is visible the next cycle.
- A simultaneous CPU write of regs 1-2 and start in the same cycle is impossible (single address). Back-to-back CPU writes in consecutive cycles are honoured.

Test Plan:
- Single layer: DESC_BASE=0x100, COUNT=1, SDRAM[0x100..0x114]={0x1000,0x2000,0x3000,2,4,28}, start -> 6 SDRAM reads at 0x100..0x114, conv writes (1,0x1000),(2,0x2000),(3,0x3000),(4,2),(5,4),(6,28), then (0,1). conv_read held while conv_waitrequest=1 for 50 cycles -> done=1, busy=0, PROGRESS=1.
- Three layers at base 0x200 -> second descriptor fetched from 0x218, third from 0x230. PROGRESS steps 1,2,3 and ends with CTRL=0b010.
- Stall handling: master_waitrequest and conv_waitrequest randomly high 50% -> address/data stable during every stall, same transaction sequence as the no-stall run.
- Bad descriptor: second descriptor has row length 2 -> err=1, done=1, PROGRESS=1, no conv writes for descriptor 2.
- COUNT=0 start -> done=1 one cycle later, zero bus strobes. A start write while busy, plus DESC_BASE=0xDEAD0 written mid-run -> both ignored, readback shows the original base.
- Reset asserted during PROG (after write j=3) -> next cycle all strobes 0 and CTRL=0. A fresh start after reset runs cleanly from descriptor 0.
